// File: rtl/huffman_dc_decoder.sv
// Bit-serial decoder for the static DC Huffman code (MSB-first, one bit per accepted cycle).
// Latency: symbol appears on the outputs one cycle after its last bit is consumed.
// Backpressure: in_ready = !out_valid || out_ready; a held symbol stalls the bit input.
//
// Ports:
//   clk, rst (async, active-high), clr (sync abort of partial symbol and pending output)
//   in_valid/in_ready/in_bit       : serial code bits, MSB of the codeword first
//   out_valid/out_ready            : decoded symbol handshake
//   dc_value (signed 11b), dc_cat (0..11, 15 = illegal prefix), code_len (5b), err
module huffman_dc_decoder #(
    parameter int MAX_PFX = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               in_valid,
    input  logic               in_bit,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [10:0] dc_value,
    output logic [3:0]         dc_cat,
    output logic [4:0]         code_len,
    output logic               err
);

    typedef enum logic {S_PFX = 1'b0, S_MAG = 1'b1} state_t;

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_pfx;        // last two prefix bits
    logic [3:0]  r_pfx_cnt;    // prefix bits consumed so far
    logic [3:0]  r_cat;
    logic [3:0]  r_plen;       // prefix length of the symbol being decoded
    logic [3:0]  r_mbits;      // magnitude bits of the symbol (1 pad bit for cat0)
    logic [3:0]  r_mag_cnt;    // magnitude bits still to come
    logic [9:0]  r_mag;        // magnitude bits already received

    logic        r_out_valid;
    logic [10:0] r_dc_value;
    logic [3:0]  r_dc_cat;
    logic [4:0]  r_code_len;
    logic        r_err;

    logic        w_take;
    logic        w_pfx_res;    // prefix resolved to a category this cycle
    logic        w_pfx_err;    // MAX_PFX consecutive ones this cycle
    logic        w_mag_done;   // last magnitude bit consumed this cycle
    logic [3:0]  w_res_cat;
    logic [3:0]  w_res_plen;
    logic [10:0] w_m;
    logic [10:0] w_mask;
    logic [10:0] w_half;
    logic        w_msb;
    logic [10:0] w_val;

    assign in_ready  = !r_out_valid || out_ready;
    assign w_take    = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign dc_value  = r_dc_value;
    assign dc_cat    = r_dc_cat;
    assign code_len  = r_code_len;
    assign err       = r_err;

    // Magnitude arithmetic. mask = 2^cat-1; subtracting it modulo 2^11 gives the
    // same 11 bits as a 12-bit subtract followed by truncation.
    assign w_m    = {r_mag, in_bit};
    assign w_mask = ~(11'h7FF << r_cat);
    assign w_half = (w_mask >> 1) ^ w_mask;
    assign w_msb  = |(w_m & w_half);
    assign w_val  = w_msb ? w_m : (w_m - w_mask);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_PFX;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pfx_res   = 1'b0;
        w_pfx_err   = 1'b0;
        w_mag_done  = 1'b0;
        w_res_cat   = 4'd0;
        w_res_plen  = 4'd0;
        if (w_take) begin
            case (r_state)
                S_PFX: begin
                    if (r_pfx_cnt == 4'd1) begin
                        if (!r_pfx[0] && !in_bit) begin
                            w_pfx_res  = 1'b1;
                            w_res_cat  = 4'd0;
                            w_res_plen = 4'd2;
                        end
                    end else if (r_pfx_cnt == 4'd2) begin
                        w_res_plen = 4'd3;
                        w_pfx_res  = 1'b1;
                        case ({r_pfx, in_bit})
                            3'b010:  w_res_cat = 4'd1;
                            3'b011:  w_res_cat = 4'd2;
                            3'b100:  w_res_cat = 4'd3;
                            3'b101:  w_res_cat = 4'd4;
                            3'b110:  w_res_cat = 4'd5;
                            default: w_pfx_res = 1'b0;  // 111: keep counting ones
                        endcase
                    end else if (r_pfx_cnt >= 4'd3) begin
                        // All bits so far are ones, so r_pfx_cnt is the ones count.
                        if (!in_bit) begin
                            w_pfx_res  = 1'b1;
                            w_res_cat  = r_pfx_cnt + 4'd3;
                            w_res_plen = r_pfx_cnt + 4'd1;
                        end else if ((r_pfx_cnt + 4'd1) == 4'(MAX_PFX)) begin
                            w_pfx_err = 1'b1;
                        end
                    end
                    if (w_pfx_res) begin
                        w_state_nxt = S_MAG;
                    end
                end
                S_MAG: begin
                    if (r_mag_cnt == 4'd1) begin
                        w_mag_done  = 1'b1;
                        w_state_nxt = S_PFX;
                    end
                end
                default: w_state_nxt = S_PFX;
            endcase
        end
        if (clr) begin
            w_state_nxt = S_PFX;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pfx       <= '0;
            r_pfx_cnt   <= '0;
            r_cat       <= '0;
            r_plen      <= '0;
            r_mbits     <= '0;
            r_mag_cnt   <= '0;
            r_mag       <= '0;
            r_out_valid <= 1'b0;
            r_dc_value  <= '0;
            r_dc_cat    <= '0;
            r_code_len  <= '0;
            r_err       <= 1'b0;
        end else if (clr) begin
            r_pfx       <= '0;
            r_pfx_cnt   <= '0;
            r_mag_cnt   <= '0;
            r_mag       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_take) begin
                if (r_state == S_PFX) begin
                    if (w_pfx_res) begin
                        r_pfx     <= '0;
                        r_pfx_cnt <= '0;
                        r_cat     <= w_res_cat;
                        r_plen    <= w_res_plen;
                        r_mbits   <= (w_res_cat == 4'd0) ? 4'd1 : w_res_cat;
                        r_mag_cnt <= (w_res_cat == 4'd0) ? 4'd1 : w_res_cat;
                        r_mag     <= '0;
                    end else if (w_pfx_err) begin
                        r_pfx     <= '0;
                        r_pfx_cnt <= '0;
                    end else begin
                        r_pfx     <= {r_pfx[0], in_bit};
                        r_pfx_cnt <= r_pfx_cnt + 4'd1;
                    end
                end else begin
                    r_mag     <= {r_mag[8:0], in_bit};
                    r_mag_cnt <= r_mag_cnt - 4'd1;
                end
            end

            if (w_pfx_err) begin
                r_out_valid <= 1'b1;
                r_dc_value  <= '0;
                r_dc_cat    <= 4'd15;
                r_code_len  <= 5'(MAX_PFX);
                r_err       <= 1'b1;
            end else if (w_mag_done) begin
                r_out_valid <= 1'b1;
                r_dc_cat    <= r_cat;
                r_code_len  <= {1'b0, r_plen} + {1'b0, r_mbits};
                if (r_cat == 4'd0) begin
                    r_dc_value <= '0;       // pad bit carries no value
                    r_err      <= 1'b0;
                end else if (r_cat == 4'd11 && w_msb) begin
                    r_dc_value <= '0;       // +1024..+2047 not representable
                    r_err      <= 1'b1;
                end else begin
                    r_dc_value <= w_val;
                    r_err      <= 1'b0;
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_huffman_dc_decoder.sv
module tb_huffman_dc_decoder;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               clr = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_bit = 1'b0;
    logic               in_ready;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [10:0] dc_value;
    logic [3:0]         dc_cat;
    logic [4:0]         code_len;
    logic               err;

    int n_checks = 0;
    int n_fail   = 0;

    huffman_dc_decoder #(.MAX_PFX(9)) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .in_valid (in_valid),
        .in_bit   (in_bit),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .dc_value (dc_value),
        .dc_cat   (dc_cat),
        .code_len (code_len),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_sym(input string tag, input int v, input int c, input int l, input int e);
        chk({tag, ".valid"}, 32'(out_valid), 1);
        chk({tag, ".value"}, 32'(dc_value), v);
        chk({tag, ".cat"},   32'(dc_cat), c);
        chk({tag, ".len"},   32'(code_len), l);
        chk({tag, ".err"},   32'(err), e);
    endtask

    // Drives n bits MSB-first on successive negedges, then drops in_valid one
    // negedge after the last bit, when the symbol must be visible.
    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_bit   = bits[i];
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst.valid", 32'(out_valid), 0);
        chk("rst.value", 32'(dc_value), 0);
        chk("rst.cat",   32'(dc_cat), 0);
        chk("rst.len",   32'(code_len), 0);
        chk("rst.err",   32'(err), 0);
        chk("rst.in_ready", 32'(in_ready), 1);
        rst = 1'b0;

        send_bits(32'b000, 3);                 chk_sym("cat0", 0, 0, 3, 0);
        send_bits(32'b0101, 4);                chk_sym("p1", 1, 1, 4, 0);
        send_bits(32'b0100, 4);                chk_sym("m1", -1, 1, 4, 0);
        send_bits(32'b01101, 5);               chk_sym("m2", -2, 2, 5, 0);
        send_bits(32'b1110101010, 10);         chk_sym("p42", 42, 6, 10, 0);
        send_bits(32'b1110010101, 10);         chk_sym("m42", -42, 6, 10, 0);
        send_bits(32'b111111101111111111, 18); chk_sym("p1023", 1023, 10, 18, 0);
        send_bits(32'b11111111001111111111, 20); chk_sym("m1024", -1024, 11, 20, 0);
        send_bits(32'b11111111010000000000, 20); chk_sym("cat11err", 0, 11, 20, 1);

        // Nine ones form an illegal prefix; decoding resumes on the next bit.
        send_bits(32'b111111111, 9);           chk_sym("pfxerr", 0, 15, 9, 1);
        send_bits(32'b000, 3);                 chk_sym("after_err", 0, 0, 3, 0);

        // Abort mid-magnitude: nothing emitted, then a clean symbol.
        send_bits(32'b111010, 6);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("clr.no_valid", 32'(out_valid), 0);
            @(negedge clk);
        end
        send_bits(32'b0100, 4);                chk_sym("after_clr", -1, 1, 4, 0);

        // Backpressure: +5 = cat3 "100" + magnitude "101".
        @(negedge clk);
        out_ready = 1'b0;
        send_bits(32'b100101, 6);              chk_sym("bp.p5", 5, 3, 6, 0);
        in_valid = 1'b1;
        in_bit   = 1'b0;                       // first bit of the next symbol, held
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp.in_ready", 32'(in_ready), 0);
            chk("bp.hold_val", 32'(dc_value), 5);
            chk("bp.hold_valid", 32'(out_valid), 1);
        end
        out_ready = 1'b1;                      // accept +5 and consume the held 0
        send_bits(32'b101, 3);                 chk_sym("bp.p1", 1, 1, 4, 0);

        // Reset in the middle of a magnitude field.
        send_bits(32'b111010, 6);
        rst = 1'b1;
        #1;
        chk("mrst.valid", 32'(out_valid), 0);
        chk("mrst.value", 32'(dc_value), 0);
        chk("mrst.cat",   32'(dc_cat), 0);
        chk("mrst.len",   32'(code_len), 0);
        chk("mrst.err",   32'(err), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst.no_valid", 32'(out_valid), 0);
        send_bits(32'b0100, 4);                chk_sym("after_rst", -1, 1, 4, 0);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
